// File: rtl/div_result_reconstructor_if.sv
// ---------------------------------------------------------------------------
// div_result_reconstructor_if
// Handshake/data bundle for div_result_reconstructor.
//   in_valid/in_ready   : sample handshake (n, d, q, r)
//   out_valid/out_ready : result handshake (recon, abs_err, exact, d_zero)
//   err_sum/err_cnt     : running error statistics, present only when
//                         DIV_RECON_ERR_ACCUM_EN is defined
// Modports: master = sample producer / result consumer, slave = the block.
// ---------------------------------------------------------------------------
interface div_result_reconstructor_if #(
  parameter int DW = 8,
  parameter int RW = 2*DW+1
);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] n;
  logic [DW-1:0]   d;
  logic [DW-1:0]   q;
  logic [DW-1:0]   r;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   recon;
  logic [RW-1:0]   abs_err;
  logic            exact;
  logic            d_zero;
`ifdef DIV_RECON_ERR_ACCUM_EN
  logic [31:0]     err_sum;
  logic [15:0]     err_cnt;
`endif

  modport master (
    output in_valid, n, d, q, r, out_ready,
    input  in_ready, out_valid, recon, abs_err, exact, d_zero
`ifdef DIV_RECON_ERR_ACCUM_EN
    , input err_sum, err_cnt
`endif
  );

  modport slave (
    input  in_valid, n, d, q, r, out_ready,
    output in_ready, out_valid, recon, abs_err, exact, d_zero
`ifdef DIV_RECON_ERR_ACCUM_EN
    , output err_sum, err_cnt
`endif
  );
endinterface

// File: rtl/div_result_reconstructor.sv
// ---------------------------------------------------------------------------
// div_result_reconstructor
// Rebuilds a dividend from a divider result as q*d + r with a sequential
// shift-add multiplier (DW cycles), then reports the reconstruction, the
// absolute error against the original dividend n and an exact-match flag.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_result_reconstructor_if.slave
//          in_valid/in_ready, n, d, q, r        - sample input
//          out_valid/out_ready, recon, abs_err,
//          exact, d_zero                        - result output
//
// Optional feature macro: DIV_RECON_ERR_ACCUM_EN
//   When defined, bus.err_sum (32b) and bus.err_cnt (16b) carry a saturating
//   running sum of abs_err and a count of delivered results.
// ---------------------------------------------------------------------------
module div_result_reconstructor #(
  parameter int DW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  div_result_reconstructor_if.slave   bus
);

  localparam int RW = 2*DW+1;
  localparam int CW = $clog2(DW+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // |a - b| on the reconstruction width
  function automatic logic [RW-1:0] abs_diff(input logic [RW-1:0] a,
                                             input logic [RW-1:0] b);
    if (a >= b) begin
      return a - b;
    end else begin
      return b - a;
    end
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic            in_ready_s;
  logic            out_valid_s;

  logic [2*DW-1:0] n_r;
  logic [RW-1:0]   acc_r;
  logic [RW-1:0]   mcand_r;
  logic [DW-1:0]   shift_r;
  logic [CW-1:0]   cnt_r;
  logic [RW-1:0]   recon_r;
  logic [RW-1:0]   abs_err_r;
  logic            exact_r;
  logic            d_zero_r;

  logic [RW-1:0]   acc_add_s;
  logic [RW-1:0]   n_ext_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MUL;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Handshake outputs, decoded from the state register only
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      MUL: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
      DONE: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Accumulator value after the current multiplier step
  always_comb begin
    n_ext_s = {1'b0, n_r};
    if (shift_r[0]) begin
      acc_add_s = acc_r + mcand_r;
    end else begin
      acc_add_s = acc_r;
    end
  end

  // Datapath: capture on accept, shift-add during MUL, latch results on the
  // final step so DONE outputs come straight from registers
  always_ff @(posedge clk) begin
    if (rst) begin
      n_r       <= '0;
      acc_r     <= '0;
      mcand_r   <= '0;
      shift_r   <= '0;
      cnt_r     <= '0;
      recon_r   <= '0;
      abs_err_r <= '0;
      exact_r   <= 1'b0;
      d_zero_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            n_r      <= bus.n;
            acc_r    <= RW'(bus.r);
            mcand_r  <= RW'(bus.d);
            shift_r  <= bus.q;
            cnt_r    <= '0;
            d_zero_r <= (bus.d == '0);
          end
        end
        MUL: begin
          acc_r   <= acc_add_s;
          mcand_r <= mcand_r << 1;
          shift_r <= shift_r >> 1;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            recon_r   <= acc_add_s;
            abs_err_r <= abs_diff(acc_add_s, n_ext_s);
            exact_r   <= (acc_add_s == n_ext_s);
          end
        end
        default: begin
          // DONE: everything holds until the result is taken
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.recon     = recon_r;
  assign bus.abs_err   = abs_err_r;
  assign bus.exact     = exact_r;
  assign bus.d_zero    = d_zero_r;

`ifdef DIV_RECON_ERR_ACCUM_EN
  logic [31:0] err_sum_r;
  logic [15:0] err_cnt_r;
  logic [32:0] sum_wide_s;
  logic [16:0] cnt_wide_s;
  logic        take_s;

  // Saturating next values for the error statistics
  always_comb begin
    take_s     = out_valid_s & bus.out_ready;
    sum_wide_s = {1'b0, err_sum_r} + 33'(abs_err_r);
    cnt_wide_s = {1'b0, err_cnt_r} + 17'd1;
  end

  // Error statistics, advanced once per delivered result
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sum_r <= 32'd0;
      err_cnt_r <= 16'd0;
    end else if (take_s) begin
      err_sum_r <= sum_wide_s[32] ? 32'hFFFF_FFFF : sum_wide_s[31:0];
      err_cnt_r <= cnt_wide_s[16] ? 16'hFFFF : cnt_wide_s[15:0];
    end
  end

  assign bus.err_sum = err_sum_r;
  assign bus.err_cnt = err_cnt_r;
`else
  // Error statistics not built in this configuration.
`endif

endmodule

// File: tb/tb_div_result_reconstructor.sv
module tb_div_result_reconstructor;

  localparam int DW = 8;
  localparam int RW = 2*DW+1;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  div_result_reconstructor_if #(.DW(DW)) bus ();

  div_result_reconstructor #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2*DW-1:0] n;
    logic [DW-1:0]   d;
    logic [DW-1:0]   q;
    logic [DW-1:0]   r;
    logic [RW-1:0]   recon;
    logic [RW-1:0]   abs_err;
    logic            exact;
    logic            d_zero;
  } vec_t;

  vec_t vecs [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [2*DW-1:0] n, input logic [DW-1:0] d,
                            input logic [DW-1:0] q, input logic [DW-1:0] r);
    bus.n = n;
    bus.d = d;
    bus.q = q;
    bus.r = r;
  endtask

  // Wait (bounded) for out_valid; returns cycles waited, or -1 on timeout
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    set_inputs(v.n, v.d, v.q, v.r);
    bus.out_ready = 1'b1;
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_recon"},   64'(bus.recon),   64'(v.recon));
    check({tag, "_abs_err"}, 64'(bus.abs_err), 64'(v.abs_err));
    check({tag, "_exact"},   64'(bus.exact),   64'(v.exact));
    check({tag, "_d_zero"},  64'(bus.d_zero),  64'(v.d_zero));
    step();
    check({tag, "_back_idle"}, 64'({bus.in_ready, bus.out_valid}), 64'd2);
  endtask

  initial begin
    int lat;
    int acc0;
    int acc1;
    bit seen;
    bit prev_ready;

    cyc    = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_inputs(16'd0, 8'd0, 8'd0, 8'd0);

    //                n       d      q      r      recon     abs_err  ex    dz
    vecs[0] = '{16'd1000,  8'd7,   8'd142, 8'd6,   17'd1000,  17'd0,     1'b1, 1'b0};
    vecs[1] = '{16'd1000,  8'd7,   8'd140, 8'd6,   17'd986,   17'd14,    1'b0, 1'b0};
    vecs[2] = '{16'd900,   8'd7,   8'd140, 8'd6,   17'd986,   17'd86,    1'b0, 1'b0};
    vecs[3] = '{16'd0,     8'd255, 8'd255, 8'd255, 17'd65280, 17'd65280, 1'b0, 1'b0};
    vecs[4] = '{16'd5,     8'd0,   8'd77,  8'd5,   17'd5,     17'd0,     1'b1, 1'b1};
    vecs[5] = '{16'd65535, 8'd1,   8'd255, 8'd0,   17'd255,   17'd65280, 1'b0, 1'b0};
    vecs[6] = '{16'd12345, 8'd100, 8'd123, 8'd45,  17'd12345, 17'd0,     1'b1, 1'b0};

    step();
    step();
    rst = 1'b0;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_recon",     64'(bus.recon),     64'd0);
    check("rst_abs_err",   64'(bus.abs_err),   64'd0);
    check("rst_exact",     64'(bus.exact),     64'd0);
    check("rst_d_zero",    64'(bus.d_zero),    64'd0);
`ifdef DIV_RECON_ERR_ACCUM_EN
    check("rst_err_sum", 64'(bus.err_sum), 64'd0);
    check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
`endif

    // Table of single samples with immediate out_ready
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
`ifdef DIV_RECON_ERR_ACCUM_EN
      if (i == 2) begin
        check("accum_err_sum", 64'(bus.err_sum), 64'd100);
        check("accum_err_cnt", 64'(bus.err_cnt), 64'd3);
      end
`endif
    end

    // Back-to-back throughput: in_valid and out_ready held high
    set_inputs(16'd1000, 8'd7, 8'd142, 8'd6);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    step();
    acc0 = cyc;
    acc1 = -1;
    prev_ready = bus.in_ready;
    for (int i = 0; i < 40; i++) begin
      step();
      if (prev_ready && !bus.in_ready) begin
        acc1 = cyc;
        break;
      end
      prev_ready = bus.in_ready;
    end
    check("b2b_spacing", 64'(acc1 - acc0), 64'd10);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("b2b_second_recon", 64'(bus.recon), 64'd1000);
    step();

    // Backpressure: result held 20 cycles while a new sample waits
    set_inputs(16'd1000, 8'd7, 8'd140, 8'd6);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    step();
    acc0 = cyc;
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd8);
    set_inputs(16'd50, 8'd5, 8'd10, 8'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("bp_hold%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_hold%0d_in_ready", i),  64'(bus.in_ready),  64'd0);
      check($sformatf("bp_hold%0d_recon", i),     64'(bus.recon),     64'd986);
      check($sformatf("bp_hold%0d_abs_err", i),   64'(bus.abs_err),   64'd14);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    step();
    acc1 = cyc;
    check("bp_accept_taken", 64'(bus.in_ready), 64'd0);
    check("bp_spacing", 64'(acc1 - acc0), 64'd30);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp_next_latency", 64'(lat), 64'd8);
    check("bp_next_recon",   64'(bus.recon), 64'd50);
    check("bp_next_exact",   64'(bus.exact), 64'd1);
    step();

    // Reset in the middle of MUL discards the sample
    set_inputs(16'd1000, 8'd7, 8'd142, 8'd6);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_recon",     64'(bus.recon),     64'd0);
`ifdef DIV_RECON_ERR_ACCUM_EN
    check("midrst_err_sum", 64'(bus.err_sum), 64'd0);
    check("midrst_err_cnt", 64'(bus.err_cnt), 64'd0);
`endif
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 64'(seen), 64'd0);
    vecs[0] = '{16'd50, 8'd5, 8'd10, 8'd0, 17'd50, 17'd0, 1'b1, 1'b0};
    run_vec(vecs[0], "after_rst");

    // Reset while holding a result in DONE
    set_inputs(16'd1000, 8'd7, 8'd140, 8'd6);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("donerst_reached", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("donerst_out_valid", 64'(bus.out_valid), 64'd0);
    check("donerst_in_ready",  64'(bus.in_ready),  64'd1);
    check("donerst_abs_err",   64'(bus.abs_err),   64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
